// File: rtl/hzdm.sv
// RAW-hazard scoreboard for the decode stage: per-register pending-write counters,
// issue stall generation and a fence drain sequencer.
module hzdm #(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       dec_valid_i,
    input  logic [4:0] dec_raddr1_i,
    input  logic       dec_rs1_used_i,
    input  logic [4:0] dec_raddr2_i,
    input  logic       dec_rs2_used_i,
    input  logic       dec_issue_i,
    input  logic       dec_reg_write_i,
    input  logic [4:0] dec_reg_addr_i,
    input  logic       wb_write_i,
    input  logic [4:0] wb_addr_i,
    input  logic       fence_req_i,
    output logic       fence_ack_o,
    output logic       stall_o,
    output logic       busy_o,
    output logic [7:0] inflight_o,
    output logic       err_o
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q [32];
    logic [CW-1:0] cnt_d [32];
    logic [7:0]    inflight_q, inflight_d;
    logic          err_q, err_d;

    logic haz, ovf;
    logic issueWr, retireOk, retireBad, sameReg;

    // Entry 0 is never written, so x0 reads as "nothing pending" without special casing.
    assign haz = (dec_rs1_used_i && dec_raddr1_i != 5'd0 && cnt_q[dec_raddr1_i] != '0)
              || (dec_rs2_used_i && dec_raddr2_i != 5'd0 && cnt_q[dec_raddr2_i] != '0);
    assign ovf = dec_reg_write_i && dec_reg_addr_i != 5'd0
              && cnt_q[dec_reg_addr_i] == CW'(MAX_INFLIGHT);

    assign stall_o = rst_i && dec_valid_i && (haz || ovf || state_q != IDLE);

    assign issueWr   = dec_issue_i && !stall_o && dec_reg_write_i && dec_reg_addr_i != 5'd0;
    assign retireOk  = wb_write_i && wb_addr_i != 5'd0 && cnt_q[wb_addr_i] != '0;
    assign retireBad = wb_write_i && wb_addr_i != 5'd0 && cnt_q[wb_addr_i] == '0;
    assign sameReg   = issueWr && retireOk && dec_reg_addr_i == wb_addr_i;

    always_comb begin
        cnt_d      = cnt_q;
        inflight_d = inflight_q;
        if (issueWr && !sameReg) begin
            cnt_d[dec_reg_addr_i] = cnt_q[dec_reg_addr_i] + CW'(1);
            inflight_d            = inflight_d + 8'd1;
        end
        if (retireOk && !sameReg) begin
            cnt_d[wb_addr_i] = cnt_q[wb_addr_i] - CW'(1);
            inflight_d       = inflight_d - 8'd1;
        end
        err_d = err_q || (dec_issue_i && stall_o) || retireBad;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            inflight_q <= 8'd0;
            err_q      <= 1'b0;
            state_q    <= IDLE;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            // DRAIN watches the registered total, so the ack trails the last retire by a cycle.
            case (state_q)
                IDLE:    if (fence_req_i) state_q <= DRAIN;
                DRAIN:   if (inflight_q == 8'd0) state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fence_ack_o = (state_q == DONE);
    assign busy_o      = (inflight_q != 8'd0);
    assign inflight_o  = inflight_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_hzdm.sv
// Directed bench for hzdm: a vector table for scoreboard behaviour plus
// hand-written sequences for reset, stalled issue and fence draining.
module tb_hzdm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       decValid, rs1Used, rs2Used, decIssue, regWrite, wbWrite, fenceReq;
    logic [4:0] raddr1, raddr2, regAddr, wbAddr;
    logic       fenceAck, stall, busy, err;
    logic [7:0] inflight;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic [4:0] a1;
        logic       u1;
        logic [4:0] a2;
        logic       u2;
        logic       iss;
        logic       rw;
        logic [4:0] rd;
        logic       wb;
        logic [4:0] wa;
        logic       fr;
        logic       eStall;
        logic [7:0] eInfl;
        logic       eErr;
        logic       eAck;
    } vec_t;

    vec_t vq[$];

    hzdm #(.MAX_INFLIGHT(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .dec_valid_i(decValid), .dec_raddr1_i(raddr1), .dec_rs1_used_i(rs1Used),
        .dec_raddr2_i(raddr2), .dec_rs2_used_i(rs2Used), .dec_issue_i(decIssue),
        .dec_reg_write_i(regWrite), .dec_reg_addr_i(regAddr),
        .wb_write_i(wbWrite), .wb_addr_i(wbAddr), .fence_req_i(fenceReq),
        .fence_ack_o(fenceAck), .stall_o(stall), .busy_o(busy),
        .inflight_o(inflight), .err_o(err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, logic [4:0] a1, logic u1, logic [4:0] a2, logic u2,
                                logic iss, logic rw, logic [4:0] rd, logic wb, logic [4:0] wa,
                                logic fr, logic eStall, logic [7:0] eInfl, logic eErr, logic eAck);
        vec_t t;
        t.v = v; t.a1 = a1; t.u1 = u1; t.a2 = a2; t.u2 = u2;
        t.iss = iss; t.rw = rw; t.rd = rd; t.wb = wb; t.wa = wa; t.fr = fr;
        t.eStall = eStall; t.eInfl = eInfl; t.eErr = eErr; t.eAck = eAck;
        return t;
    endfunction

    task automatic applyStimulus(input vec_t t);
        decValid = t.v;   raddr1 = t.a1;  rs1Used = t.u1;
        raddr2   = t.a2;  rs2Used = t.u2; decIssue = t.iss;
        regWrite = t.rw;  regAddr = t.rd;
        wbWrite  = t.wb;  wbAddr = t.wa;  fenceReq = t.fr;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic doReset(input bit randomIn);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (randomIn) begin
                decValid = 1'b1; raddr1 = 5'($urandom); rs1Used = 1'($urandom);
                raddr2 = 5'($urandom); rs2Used = 1'($urandom); decIssue = 1'($urandom);
                regWrite = 1'($urandom); regAddr = 5'($urandom);
                wbWrite = 1'($urandom); wbAddr = 5'($urandom); fenceReq = 1'($urandom);
            end else begin
                idleInputs();
            end
            #1;
            if (randomIn) checkOutput($sformatf("reset stall %0d", i), stall, 0);
            cycle();
        end
        rst = 1'b1;
        idleInputs();
    endtask

    // Drive one record, check the combinational stall, then the registered outputs after the edge.
    task automatic runVec(input string name, input vec_t t);
        applyStimulus(t);
        #1;
        checkOutput({name, " stall"}, stall, t.eStall);
        cycle();
        checkOutput({name, " inflight"}, inflight, t.eInfl);
        checkOutput({name, " busy"}, busy, (t.eInfl != 8'd0) ? 1 : 0);
        checkOutput({name, " err"}, err, t.eErr);
        checkOutput({name, " ack"}, fenceAck, t.eAck);
    endtask

    initial begin
        // v a1 u1 a2 u2 iss rw rd wb wa fr | stall infl err ack
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vq.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 0));
        vq.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 2, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 3, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1, 3, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 9, 1, 9, 0, 1, 2, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 3, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 4, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 1, 4, 1, 4, 0, 0, 4, 0, 0));
        vq.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 1, 4, 0, 1, 3, 0, 0));
        vq.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 3, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0));
        vq.push_back(mk(1, 9, 1, 0, 0, 1, 1, 20, 0, 0, 0, 1, 3, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 2, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 1, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1, 0));

        idleInputs();
        doReset(1'b1);
        checkOutput("reset inflight", inflight, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset ack", fenceAck, 0);

        for (int i = 0; i < vq.size(); i++) begin
            runVec($sformatf("vec%0d", i), vq[i]);
        end

        // Issue while stalled is dropped and flags a protocol error.
        doReset(1'b0);
        runVec("stIss wr10", mk(1, 0, 0, 0, 0, 1, 1, 10, 0, 0, 0, 0, 1, 0, 0));
        runVec("stIss blocked", mk(1, 10, 1, 0, 0, 1, 1, 11, 0, 0, 0, 1, 1, 1, 0));

        // Fence with two writes in flight: stall holds until the ack cycle ends.
        doReset(1'b0);
        runVec("fnc wr3", mk(1, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 1, 0, 0));
        runVec("fnc wr6", mk(1, 0, 0, 0, 0, 1, 1, 6, 0, 0, 0, 0, 2, 0, 0));
        runVec("fnc req", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0));
        runVec("fnc drain0", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        runVec("fnc ret3", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 1, 0, 0));
        runVec("fnc ret6", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 1, 0, 0, 0));
        runVec("fnc toDone", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        runVec("fnc inDone", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        runVec("fnc idle", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Empty fence: ack appears two cycles after the request.
        runVec("fnc0 req", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        runVec("fnc0 drain", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        runVec("fnc0 after", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset in the middle of a drain must not produce an ack.
        runVec("rstD wr8", mk(1, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0, 0, 1, 0, 0));
        runVec("rstD req", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        runVec("rstD drain", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        doReset(1'b0);
        for (int i = 0; i < 4; i++) begin
            runVec($sformatf("rstD post%0d", i), mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hzdm.md
Name: hzdm

Overview:
- RAW-hazard scoreboard and issue controller for the decode stage.
- Tracks in-flight register writes between decode issue and write-back.
- Holds decode while a source register it reads still has a pending write.
- Sequences a drain (fence) so that all in-flight writes retire before a fence is acknowledged.

Parameters:
MAX_INFLIGHT, 3, maximum outstanding writes per destination register; per-register counter width CW = clog2(MAX_INFLIGHT+1)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active-low
dec_valid_i  input  1  decode holds a valid instruction
dec_raddr1_i  input  5  source register 1 address
dec_rs1_used_i  input  1  instruction reads rs1
dec_raddr2_i  input  5  source register 2 address
dec_rs2_used_i  input  1  instruction reads rs2
dec_issue_i  input  1  decode output handshake fired this cycle (valid && ready)
dec_reg_write_i  input  1  issued instruction writes a register
dec_reg_addr_i  input  5  destination of issued instruction
wb_write_i  input  1  write-back retires a register write this cycle
wb_addr_i  input  5  retired destination
fence_req_i  input  1  request drain of all in-flight writes
fence_ack_o  output  1  one-cycle pulse when drain is complete
stall_o  output  1  decode must not issue (combinational)
busy_o  output  1  at least one write in flight (registered)
inflight_o  output  8  total in-flight writes (registered)
err_o  output  1  sticky protocol-error flag

Behaviour:
- Reset (rst_i=0 at a rising edge):
  - All counters cnt[1..31] = 0, inflight_o = 0, state = IDLE.
  - fence_ack_o = 0, busy_o = 0, err_o = 0.
  - stall_o = 0 while reset is held.
  - Reset mid-drain abandons the drain; no ack is produced.
- Register x0 is never tracked:
  - A destination of 0 does not count.
  - A source of 0 never stalls.
- Hazard term haz:
  - (rs1_used && raddr1 != 0 && cnt[raddr1] != 0) || (rs2_used && raddr2 != 0 && cnt[raddr2] != 0).
  - Uses registered counters only; there is no same-cycle bypass from wb_write_i.
- Overflow term ovf: dec_reg_write_i && dec_reg_addr_i != 0 && cnt[dec_reg_addr_i] == MAX_INFLIGHT.
- stall_o = dec_valid_i && (haz || ovf || state != IDLE).
- Valid issue: dec_issue_i && !stall_o.
  - If it writes a nonzero register: cnt[rd] += 1 and inflight += 1 at the next edge.
- dec_issue_i while stall_o = 1:
  - Ignored; no counter change.
  - err_o set.
- Retire: wb_write_i && wb_addr_i != 0 && cnt[wb_addr_i] != 0 gives cnt -= 1 and inflight -= 1.
  - A retire to a counter already at 0 is ignored and sets err_o.
  - wb_write_i with wb_addr_i = 0 is ignored silently.
- Valid issue and retire to the same register in the same cycle: that counter is unchanged, inflight unchanged.
- Issue and retire to different registers: both applied, inflight unchanged.
- busy_o = (inflight_o != 0).
- err_o clears only on reset.
- Fence FSM:
  - IDLE: fence_req_i moves to DRAIN at the next edge. A same-cycle issue is still accepted.
  - DRAIN: forces stall_o when dec_valid_i. Retires continue. When registered inflight_o == 0, move to DONE. fence_req_i is ignored.
  - DONE: fence_ack_o = 1 for exactly this cycle; decode is still stalled. Move to IDLE unconditionally.
  - Minimum request-to-ack latency is 2 cycles (IDLE to DRAIN to DONE), even with nothing in flight.
  - A fence_req_i held high in DONE re-enters DRAIN from IDLE one cycle later.
- fence_ack_o is registered, decoded from state.
- stall_o is the only combinational output.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with random inputs -> stall_o=0, inflight_o=0, busy_o=0, err_o=0, fence_ack_o=0.
- RAW stall: issue write to x5; next cycle dec_valid, rs1=x5 -> stall_o=1. Retire x5 -> stall_o=0 on the following cycle, not in the retire cycle.
- x0 and unused sources:
  - Issue write to x0 -> inflight_o stays 0.
  - rs2=x7 with rs2_used=0 while cnt[x7]=1 -> stall_o=0.
- Saturation: 3 issues writing x9 (MAX_INFLIGHT=3) -> 4th instruction writing x9 gives stall_o=1, inflight_o=3. One retire -> issue allowed, inflight_o returns to 3.
- Simultaneous events:
  - Issue x4 and retire x4 in the same cycle with cnt[x4]=1 -> cnt[x4]=1, inflight_o unchanged.
  - Retire x12 with cnt=0 -> err_o=1 and stays 1.
- Fence:
  - With 2 writes in flight, pulse fence_req_i -> stall_o=1 throughout; ack pulses 1 cycle after the second retire is registered, then stall releases.
  - Fence with inflight 0 -> ack exactly 2 cycles after the request.
  - rst_i=0 during DRAIN -> no ack.
